perf_counter_bank: RTL and testbench
====================================

// Module: perf_counter_bank
// PURPOSE
//   Bank of NUM_CH free-running event counters with per-channel enable/clear,
//   software-selectable cascading of adjacent channels into wider counters,
//   coherent snapshot of all channels, sticky overflow flags and a masked IRQ.
//   Sits behind the AXI-Lite register slave of the counter IP; the slave drives
//   the control vectors and reads the count, snapshot and flag outputs.
// PARAMETERS
//   NUM_CH     4   number of counter channels (>=2)
//   CNT_WIDTH  32  width of each channel counter in bits (8..32)
// PORTS
//   clk        in   1                 single clock; all logic on rising edge
//   resetn     in   1                 synchronous, active-low reset
//   enable     in   NUM_CH            per-channel count enable (level)
//   clear      in   NUM_CH            per-channel synchronous clear (level)
//   cascade    in   NUM_CH            bit i=1: ch i counts carries of ch i-1; bit 0 ignored
//   snap_req   in   1                 pulse: capture all channels
//   ovf_clr    in   NUM_CH            write-1-to-clear for sticky overflow flags
//   irq_mask   in   NUM_CH            1 = flag of channel i drives irq
//   cnt_out    out  NUM_CH*CNT_WIDTH  live counter values, ch i at [i*CNT_WIDTH +: CNT_WIDTH]
//   snap_out   out  NUM_CH*CNT_WIDTH  snapshot registers, same packing
//   snap_valid out  1                 one-cycle pulse when snap_out updated
//   ovf_flag   out  NUM_CH            sticky overflow flags
//   irq        out  1                 |(ovf_flag & irq_mask), registered
// BEHAVIOUR
// - Reset (resetn=0 at edge): cnt_out, snap_out, ovf_flag = 0; snap_valid, irq = 0.
// - inc[0] = enable[0]. For i>=1: inc[i] = cascade[i] ? carry[i-1] : enable[i];
//   carry[i] = inc[i] & (cnt[i] == all-ones). Chain ripples combinationally within
//   one cycle (e.g. ch0..ch2 cascaded form a 3*CNT_WIDTH counter).
// - enable[i] is ignored while cascade[i]=1.
// - Per edge: clear[i]=1 -> cnt[i]<=0 (priority over inc); else inc[i] -> cnt[i]+1 mod 2^CNT_WIDTH.
//   Clearing ch i still yields no carry from ch i; higher chained channels are
//   cleared only by their own clear bit.
// - Latency: an enable sampled at edge k is visible on cnt_out after edge k.
// - Overflow: wrap of ch i (carry[i]=1 and clear[i]=0) sets ovf_flag[i] only if ch i is
//   the top of its chain (i==NUM_CH-1 or cascade[i+1]=0); wraps of lower chain members are
//   not flagged.
// - ovf_flag[i] cleared by ovf_clr[i]=1; set wins if set and clear occur in the same cycle.
// - irq registered: irq at edge k+1 reflects flags/mask after edge k (1-cycle after flag).
// - Snapshot: snap_req=1 at edge k -> snap_out <= cnt values held before edge k
//   (pre-increment, pre-clear), all channels from the same cycle; snap_valid=1 for the
//   cycle following edge k. Back-to-back snap_req captures every cycle, snap_valid stays high.
// - cascade changes take effect at the next edge; counter values are not altered.
// - Reset mid-operation zeroes everything in that cycle; a concurrent snap_req is dropped.
// TESTING
// - Reset: drive inputs active, resetn=0 for 2 cycles -> all outputs 0, irq=0.
// - Single channel: enable[1]=1 for 10 cycles, clear asserted on cycle 6 -> cnt1
//   shows 1..5, 0, then 1..4; other channels stay 0.
// - Wrap/flag: CNT_WIDTH=8, ch0 enabled 256 cycles -> cnt0 returns to 0, ovf_flag[0]=1,
//   irq=1 one cycle later with irq_mask[0]=1; ovf_clr[0] same cycle as new wrap -> flag stays 1.
// - Cascade: CNT_WIDTH=8, cascade[1]=1, ch0 enabled 300 cycles -> {cnt1,cnt0}=300 (0x012C),
//   ovf_flag[0]=0; 65536 cycles -> both 0, ovf_flag[1]=1.
// - Snapshot: ch0..ch3 enabled, snap_req when cnt0=41 -> snap0=41 next cycle, snap_valid
//   1 cycle; live cnt0=42 and continues; clear+snap_req same cycle -> snap holds pre-clear value.

Source files
------------

// File: rtl/perf_counter_bank.sv
// perf_counter_bank: bank of event counters with cascading into wider counters,
// coherent snapshot capture, sticky overflow flags and a masked, registered irq.
module perf_counter_bank #(
  parameter int NUM_CH    = 4,
  parameter int CNT_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [NUM_CH-1:0]             enable,
  input  logic [NUM_CH-1:0]             clear,
  input  logic [NUM_CH-1:0]             cascade,
  input  logic                          snap_req,
  input  logic [NUM_CH-1:0]             ovf_clr,
  input  logic [NUM_CH-1:0]             irq_mask,
  output logic [NUM_CH*CNT_WIDTH-1:0]   cnt_out,
  output logic [NUM_CH*CNT_WIDTH-1:0]   snap_out,
  output logic                          snap_valid,
  output logic [NUM_CH-1:0]             ovf_flag,
  output logic                          irq
);

  localparam int TOT_W = NUM_CH * CNT_WIDTH;

  logic [TOT_W-1:0]  cnt_q, cnt_d;
  logic [TOT_W-1:0]  snap_q, snap_d;
  logic              snap_valid_q, snap_valid_d;
  logic [NUM_CH-1:0] ovf_q, ovf_d;
  logic              irq_q, irq_d;

  logic [NUM_CH-1:0] inc;
  logic [NUM_CH-1:0] carry;
  logic [NUM_CH-1:0] casc_up;
  logic [NUM_CH-1:0] top;

  // A channel is the top of its chain when the channel above does not consume its carry.
  assign casc_up = {1'b0, cascade[NUM_CH-1:1]};
  assign top     = ~casc_up;

  // Ripple the increment/carry chain from channel 0 upward within one cycle.
  always_comb begin
    logic chain_in;
    inc      = '0;
    carry    = '0;
    chain_in = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      // cascade[0] has no lower neighbour, so channel 0 always follows its enable
      inc[i]   = (i != 0 && cascade[i]) ? chain_in : enable[i];
      // a cleared channel never passes a carry upward, even when it is all-ones
      carry[i] = inc[i] & (&cnt_q[i*CNT_WIDTH +: CNT_WIDTH]) & ~clear[i];
      chain_in = carry[i];
    end
  end

  // Next counter values: clear has priority over increment.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (clear[i]) begin
        cnt_d[i*CNT_WIDTH +: CNT_WIDTH] = '0;
      end else if (inc[i]) begin
        cnt_d[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i*CNT_WIDTH +: CNT_WIDTH] + 1'b1;
      end
    end
  end

  // Sticky flags (new wrap beats write-1-clear), snapshot of pre-edge counts, irq from current flags.
  always_comb begin
    ovf_d        = (ovf_q & ~ovf_clr) | (carry & top);
    snap_d       = snap_req ? cnt_q : snap_q;
    snap_valid_d = snap_req;
    irq_d        = |(ovf_q & irq_mask);
  end

  // State registers with synchronous active-low reset; reset also drops a pending snapshot.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q        <= '0;
      snap_q       <= '0;
      snap_valid_q <= 1'b0;
      ovf_q        <= '0;
      irq_q        <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      snap_q       <= snap_d;
      snap_valid_q <= snap_valid_d;
      ovf_q        <= ovf_d;
      irq_q        <= irq_d;
    end
  end

  assign cnt_out    = cnt_q;
  assign snap_out   = snap_q;
  assign snap_valid = snap_valid_q;
  assign ovf_flag   = ovf_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Testbench for perf_counter_bank: directed scenarios plus randomized traffic
// compared against a behavioural model of the counter bank.
module tb_perf_counter_bank;

  localparam int NUM_CH = 4;
  localparam int CW     = 8;
  localparam int TW     = NUM_CH * CW;

  logic              clk;
  logic              resetn;
  logic [NUM_CH-1:0] enable, clear, cascade, ovf_clr, irq_mask;
  logic              snap_req;
  logic [TW-1:0]     cnt_out, snap_out;
  logic              snap_valid;
  logic [NUM_CH-1:0] ovf_flag;
  logic              irq;

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural model state
  int       m_cnt [NUM_CH];
  int       m_snap[NUM_CH];
  bit [3:0] m_ovf;
  bit       m_sv;
  bit       m_irq;

  perf_counter_bank #(.NUM_CH(NUM_CH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .clear(clear), .cascade(cascade),
    .snap_req(snap_req), .ovf_clr(ovf_clr), .irq_mask(irq_mask),
    .cnt_out(cnt_out), .snap_out(snap_out), .snap_valid(snap_valid),
    .ovf_flag(ovf_flag), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [TW-1:0] model_cnt();
    logic [TW-1:0] r;
    for (int i = 0; i < NUM_CH; i++) r[i*CW +: CW] = CW'(m_cnt[i]);
    return r;
  endfunction

  function automatic logic [TW-1:0] model_snap();
    logic [TW-1:0] r;
    for (int i = 0; i < NUM_CH; i++) r[i*CW +: CW] = CW'(m_snap[i]);
    return r;
  endfunction

  // One clock edge of the model, using plain integer arithmetic on each counter.
  task automatic model_update();
    int       pre[NUM_CH];
    bit [3:0] ovf_pre;
    bit [3:0] setv;
    bit [4:0] casc_ext;
    bit       lower_wrapped, wrapped, do_inc;
    int       n;
    if (!resetn) begin
      for (int i = 0; i < NUM_CH; i++) begin m_cnt[i] = 0; m_snap[i] = 0; end
      m_ovf = '0; m_sv = 0; m_irq = 0;
      return;
    end
    for (int i = 0; i < NUM_CH; i++) pre[i] = m_cnt[i];
    ovf_pre  = m_ovf;
    m_irq    = |(ovf_pre & irq_mask);
    m_sv     = snap_req;
    if (snap_req) for (int i = 0; i < NUM_CH; i++) m_snap[i] = pre[i];
    casc_ext = {1'b0, cascade};
    lower_wrapped = 0;
    setv = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      do_inc = (i > 0 && cascade[i]) ? lower_wrapped : enable[i];
      if (clear[i]) begin
        m_cnt[i] = 0;
        wrapped  = 0;
      end else begin
        n        = pre[i] + int'(do_inc);
        wrapped  = (n == (1 << CW));
        m_cnt[i] = n % (1 << CW);
      end
      if (wrapped && !casc_ext[i+1]) setv[i] = 1;
      lower_wrapped = wrapped;
    end
    m_ovf = (ovf_pre & ~ovf_clr) | setv;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    resetn = 1; enable = '0; clear = '0; cascade = '0; snap_req = 0;
    ovf_clr = '0; irq_mask = '0;
  endtask

  task automatic clear_all();
    idle();
    clear = '1; ovf_clr = '1;
    cycle();
    clear = '0; ovf_clr = '0;
    cycle();
  endtask

  task automatic test_reset();
    resetn = 0; enable = '1; clear = '0; cascade = 4'b1010; snap_req = 1;
    ovf_clr = '0; irq_mask = '1;
    cycle();
    cycle();
    n_checks++; if (cnt_out !== '0) begin n_fail++; $display("FAIL reset_cnt: got %h expected 0", cnt_out); end
    n_checks++; if (snap_out !== '0) begin n_fail++; $display("FAIL reset_snap: got %h expected 0", snap_out); end
    n_checks++; if (snap_valid !== 1'b0) begin n_fail++; $display("FAIL reset_snap_valid: got %b expected 0", snap_valid); end
    n_checks++; if (ovf_flag !== '0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", ovf_flag); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", irq); end
    idle();
  endtask

  task automatic test_single_channel();
    int exp;
    clear_all();
    enable = 4'b0010;
    for (int c = 1; c <= 10; c++) begin
      clear = (c == 6) ? 4'b0010 : 4'b0000;
      cycle();
      exp = (c < 6) ? c : ((c == 6) ? 0 : c - 6);
      n_checks++;
      if (cnt_out[15:8] !== 8'(exp)) begin
        n_fail++; $display("FAIL single_cnt1 c=%0d: got %0d expected %0d", c, cnt_out[15:8], exp);
      end
      n_checks++;
      if ({cnt_out[31:16], cnt_out[7:0]} !== 24'h0) begin
        n_fail++; $display("FAIL single_others c=%0d: got %h expected 0", c, cnt_out);
      end
    end
    clear = '0;
  endtask

  task automatic test_wrap_flag();
    clear_all();
    irq_mask = 4'b0001;
    enable   = 4'b0001;
    repeat (255) cycle();
    n_checks++; if (cnt_out[7:0] !== 8'd255) begin n_fail++; $display("FAIL wrap_pre_cnt: got %0d expected 255", cnt_out[7:0]); end
    n_checks++; if (ovf_flag !== 4'b0000) begin n_fail++; $display("FAIL wrap_pre_flag: got %b expected 0000", ovf_flag); end
    cycle();
    n_checks++; if (cnt_out[7:0] !== 8'd0) begin n_fail++; $display("FAIL wrap_cnt: got %0d expected 0", cnt_out[7:0]); end
    n_checks++; if (ovf_flag !== 4'b0001) begin n_fail++; $display("FAIL wrap_flag: got %b expected 0001", ovf_flag); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL wrap_irq_early: got %b expected 0", irq); end
    cycle();
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL wrap_irq: got %b expected 1", irq); end
    n_checks++; if (cnt_out[7:0] !== 8'd1) begin n_fail++; $display("FAIL wrap_cnt_after: got %0d expected 1", cnt_out[7:0]); end
    ovf_clr = 4'b0001;
    cycle();
    ovf_clr = 4'b0000;
    n_checks++; if (ovf_flag[0] !== 1'b0) begin n_fail++; $display("FAIL ovf_clr: got %b expected 0", ovf_flag[0]); end
    for (int k = 0; k < 300 && m_cnt[0] != 255; k++) cycle();
    ovf_clr = 4'b0001;
    cycle();
    ovf_clr = 4'b0000;
    n_checks++; if (ovf_flag[0] !== 1'b1) begin n_fail++; $display("FAIL set_beats_clr: got %b expected 1", ovf_flag[0]); end
    n_checks++; if (cnt_out[7:0] !== 8'd0) begin n_fail++; $display("FAIL set_beats_clr_cnt: got %0d expected 0", cnt_out[7:0]); end
    idle();
  endtask

  task automatic test_cascade();
    clear_all();
    cascade = 4'b0010;
    enable  = 4'b0001;
    repeat (300) cycle();
    n_checks++; if (cnt_out[15:0] !== 16'h012C) begin n_fail++; $display("FAIL cascade_300: got %h expected 012c", cnt_out[15:0]); end
    n_checks++; if (ovf_flag !== 4'b0000) begin n_fail++; $display("FAIL cascade_300_flag: got %b expected 0000", ovf_flag); end
    repeat (65536 - 300) cycle();
    n_checks++; if (cnt_out !== '0) begin n_fail++; $display("FAIL cascade_wrap_cnt: got %h expected 0", cnt_out); end
    n_checks++; if (ovf_flag !== 4'b0010) begin n_fail++; $display("FAIL cascade_wrap_flag: got %b expected 0010", ovf_flag); end
    idle();
  endtask

  task automatic test_snapshot();
    clear_all();
    enable = 4'b1111;
    repeat (41) cycle();
    n_checks++; if (cnt_out[7:0] !== 8'd41) begin n_fail++; $display("FAIL snap_setup: got %0d expected 41", cnt_out[7:0]); end
    snap_req = 1;
    cycle();
    snap_req = 0;
    n_checks++; if (snap_out !== 32'h29292929) begin n_fail++; $display("FAIL snap_value: got %h expected 29292929", snap_out); end
    n_checks++; if (snap_valid !== 1'b1) begin n_fail++; $display("FAIL snap_valid: got %b expected 1", snap_valid); end
    n_checks++; if (cnt_out[7:0] !== 8'd42) begin n_fail++; $display("FAIL snap_live: got %0d expected 42", cnt_out[7:0]); end
    cycle();
    n_checks++; if (snap_valid !== 1'b0) begin n_fail++; $display("FAIL snap_valid_drop: got %b expected 0", snap_valid); end
    n_checks++; if (snap_out !== 32'h29292929) begin n_fail++; $display("FAIL snap_hold: got %h expected 29292929", snap_out); end
    clear = 4'b0001; snap_req = 1;
    cycle();
    clear = 4'b0000;
    n_checks++; if (snap_out[7:0] !== 8'd43) begin n_fail++; $display("FAIL snap_preclear: got %0d expected 43", snap_out[7:0]); end
    n_checks++; if (cnt_out[7:0] !== 8'd0) begin n_fail++; $display("FAIL snap_clear_cnt: got %0d expected 0", cnt_out[7:0]); end
    cycle();
    snap_req = 0;
    n_checks++; if (snap_valid !== 1'b1) begin n_fail++; $display("FAIL snap_b2b_valid: got %b expected 1", snap_valid); end
    n_checks++; if (snap_out[15:0] !== 16'h2C00) begin n_fail++; $display("FAIL snap_b2b_value: got %h expected 2c00", snap_out[15:0]); end
    idle();
  endtask

  task automatic test_random();
    clear_all();
    for (int c = 0; c < 3000; c++) begin
      resetn   = ($urandom_range(63) != 0);
      enable   = 4'($urandom | $urandom);
      clear    = ($urandom_range(15) == 0) ? 4'($urandom) : 4'b0000;
      if ($urandom_range(31) == 0) cascade = 4'($urandom);
      if ($urandom_range(15) == 0) irq_mask = 4'($urandom);
      snap_req = ($urandom_range(3) == 0);
      ovf_clr  = ($urandom_range(7) == 0) ? 4'($urandom) : 4'b0000;
      cycle();
      n_checks++; if (cnt_out !== model_cnt()) begin n_fail++; $display("FAIL rand_cnt c=%0d: got %h expected %h", c, cnt_out, model_cnt()); end
      n_checks++; if (snap_out !== model_snap()) begin n_fail++; $display("FAIL rand_snap c=%0d: got %h expected %h", c, snap_out, model_snap()); end
      n_checks++; if (snap_valid !== m_sv) begin n_fail++; $display("FAIL rand_snap_valid c=%0d: got %b expected %b", c, snap_valid, m_sv); end
      n_checks++; if (ovf_flag !== m_ovf) begin n_fail++; $display("FAIL rand_ovf c=%0d: got %b expected %b", c, ovf_flag, m_ovf); end
      n_checks++; if (irq !== m_irq) begin n_fail++; $display("FAIL rand_irq c=%0d: got %b expected %b", c, irq, m_irq); end
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_single_channel();
    test_wrap_flag();
    test_cascade();
    test_snapshot();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
